// File: rtl/spatial_encoder_pkg.sv
// Shared constants, state encoding and the channel-binding permutation
// for the spatial encoder.
package spatial_encoder_pkg;

    localparam int HV_DIMENSION       = 32;
    localparam int MAX_FEATURE_WIDTH  = 4;
    localparam int NUM_CHANNEL_WIDTH  = 3;
    localparam int MAJORITY_THRESHOLD = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Binding: result[i] = hv[(i - sh) mod D], i.e. rotate left by sh.
    function automatic logic [HV_DIMENSION-1:0] rotl_hv(
        input logic [HV_DIMENSION-1:0]      hv,
        input logic [NUM_CHANNEL_WIDTH-1:0] sh
    );
        logic [2*HV_DIMENSION-1:0] dbl;
        dbl = {hv, hv};
        return dbl[HV_DIMENSION - int'(sh) +: HV_DIMENSION];
    endfunction

endpackage

// File: rtl/spatial_encoder_hv_vote_counter.sv
// One dimension's saturation-free vote counter: clears on frame accept,
// adds up to two vote bits per enabled cycle, flags majority.
module hv_vote_counter #(
    parameter int COUNT_WIDTH = 3,
    parameter int THRESHOLD   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr_i,
    input  logic                   add_i,
    input  logic                   vote0_i,
    input  logic                   vote1_i,
    output logic [COUNT_WIDTH-1:0] count_o,
    output logic                   major_o
);

    logic [COUNT_WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (add_i) begin
            count_d = count_q + COUNT_WIDTH'(vote0_i) + COUNT_WIDTH'(vote1_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign major_o = (count_q >= COUNT_WIDTH'(THRESHOLD));

endmodule

// File: rtl/spatial_encoder.sv
// Sequences one frame of feature levels through the CIM lookup, binds each
// returned vector to its channel by rotation and bundles by majority vote.
module spatial_encoder
    import spatial_encoder_pkg::*;
#(
    parameter int NUM_CHANNELS = 6,
    parameter int COUNT_WIDTH  = 3
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [NUM_CHANNELS*MAX_FEATURE_WIDTH-1:0] features,
    output logic [MAX_FEATURE_WIDTH-1:0]              curr_feature,
    output logic [NUM_CHANNEL_WIDTH-1:0]              cim_fidx,
    input  logic [HV_DIMENSION-1:0]                   cim,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [HV_DIMENSION-1:0]                   out_hv
);

    localparam logic [NUM_CHANNEL_WIDTH-1:0] LAST_CH = NUM_CHANNEL_WIDTH'(NUM_CHANNELS - 1);

    state_t                                    state_q, state_d;
    logic [NUM_CHANNEL_WIDTH-1:0]              ch_q, ch_d;
    logic                                      drain_q, drain_d;
    logic [NUM_CHANNELS*MAX_FEATURE_WIDTH-1:0] frame_q, frame_d;
    logic [HV_DIMENSION-1:0]                   out_hv_q, out_hv_d;
    logic                                      out_valid_q, out_valid_d;
    logic                                      clear_votes;

    // Tracks which channel the registered CIM output currently belongs to.
    logic                         vld1_q;
    logic [NUM_CHANNEL_WIDTH-1:0] ch1_q;
    logic [HV_DIMENSION-1:0]      bound0_q;
    logic [HV_DIMENSION-1:0]      bound;
    logic [HV_DIMENSION-1:0]      major_w;
    logic                         tie_en;

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        drain_d     = drain_q;
        frame_d     = frame_q;
        out_hv_d    = out_hv_q;
        out_valid_d = out_valid_q;
        clear_votes = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d     = ST_FETCH;
                    ch_d        = '0;
                    frame_d     = features;
                    clear_votes = 1'b1;
                end
            end
            ST_FETCH: begin
                if (ch_q == LAST_CH) begin
                    state_d = ST_DRAIN;
                    drain_d = 1'b0;
                end else begin
                    ch_d = ch_q + NUM_CHANNEL_WIDTH'(1);
                end
            end
            ST_DRAIN: begin
                if (drain_q) begin
                    state_d     = ST_DONE;
                    out_hv_d    = major_w;
                    out_valid_d = 1'b1;
                end else begin
                    drain_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ch_q        <= '0;
            drain_q     <= 1'b0;
            frame_q     <= '0;
            out_hv_q    <= '0;
            out_valid_q <= 1'b0;
            vld1_q      <= 1'b0;
            ch1_q       <= '0;
            bound0_q    <= '0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            drain_q     <= drain_d;
            frame_q     <= frame_d;
            out_hv_q    <= out_hv_d;
            out_valid_q <= out_valid_d;
            vld1_q      <= (state_q == ST_FETCH);
            ch1_q       <= ch_q;
            if (vld1_q && ch1_q == '0) begin
                bound0_q <= bound;
            end
        end
    end

    assign bound  = rotl_hv(cim, ch1_q);
    assign tie_en = vld1_q && (ch1_q == NUM_CHANNEL_WIDTH'(1));

    // Per-dimension count is exposed for debug only; the majority bit drives out_hv.
    logic [COUNT_WIDTH-1:0] unused_vote_count [HV_DIMENSION];

    generate
        for (genvar gi = 0; gi < HV_DIMENSION; gi++) begin : g_vote
            hv_vote_counter #(
                .COUNT_WIDTH (COUNT_WIDTH),
                .THRESHOLD   (MAJORITY_THRESHOLD)
            ) u_cnt (
                .clk     (clk),
                .rst_n   (rst_n),
                .clr_i   (clear_votes),
                .add_i   (vld1_q),
                .vote0_i (bound[gi]),
                .vote1_i (tie_en & (bound0_q[gi] ^ bound[gi])),
                .count_o (unused_vote_count[gi]),
                .major_o (major_w[gi])
            );
        end
    endgenerate

    assign in_ready     = (state_q == ST_IDLE);
    assign cim_fidx     = (state_q == ST_FETCH) ? ch_q : '0;
    assign curr_feature = (state_q == ST_FETCH)
                        ? frame_q[int'(ch_q) * MAX_FEATURE_WIDTH +: MAX_FEATURE_WIDTH]
                        : '0;
    assign out_valid    = out_valid_q;
    assign out_hv       = out_hv_q;

endmodule
